pc_fetch_stage: RTL

- Program counter register and instruction fetch stage. It sits directly downstream of the next-PC select mux (MUX C) and closes the loop back into it.
- Holds the PC, drives the instruction memory request/ack port, and captures the returned word into the instruction register (IR) with a valid/ready handshake to decode.
- Exports PC+1 as the mux's sequential input and loads the mux's selected output as the next PC.

---
 rtl/pc_fetch_stage.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_stage.sv
// Program counter register and instruction fetch stage: drives the imem request port and
// hands fetched words to decode through ir with a valid/ready handshake and a one-entry skid.
// Define FETCH_PERF_CNT_EN to add the fetch_count / stall_count performance counters.
module pc_fetch_stage #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(32'h0000_0000)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] next_pc,
  input  logic          flush,
  output logic [AW-1:0] pc_1,
  output logic [AW-1:0] pc,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  output logic [DW-1:0] ir,
  output logic [AW-1:0] ir_pc,
  output logic [AW-1:0] ir_pc_1,
  output logic          ir_valid,
  input  logic          ir_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_count,
  output logic [31:0]   stall_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic [AW-1:0] ir_pc_1_q, ir_pc_1_d;
  logic          ir_valid_q, ir_valid_d;
  logic [DW-1:0] skid_q, skid_d;

  logic          slot_free;
  logic          ir_load;
  logic [DW-1:0] load_word;
  logic [AW-1:0] pc_inc;

  assign pc_inc    = pc_q + AW'(1);
  assign slot_free = !ir_valid_q || ir_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; flush overrides everything except reset
  always_comb begin
    state_d = state_q;
    if (flush) begin
      unique case (state_q)
        S_REQ,
        S_DROP:  state_d = imem_ack ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_REQ;
        S_REQ:   if (imem_ack && !slot_free) state_d = S_HOLD;
        S_HOLD:  if (ir_ready) state_d = S_REQ;
        S_DROP:  if (imem_ack) state_d = S_REQ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    imem_req = 1'b0;
    unique case (state_q)
      S_REQ,
      S_DROP:  imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // A word enters ir either straight from memory or out of the skid buffer
  always_comb begin
    ir_load   = 1'b0;
    load_word = skid_q;
    if (!flush) begin
      unique case (state_q)
        S_REQ: begin
          if (imem_ack && slot_free) begin
            ir_load   = 1'b1;
            load_word = imem_rdata;
          end
        end
        S_HOLD: begin
          if (ir_ready) ir_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_pc_1_d  = ir_pc_1_q;
    ir_valid_d = ir_valid_q;
    skid_d     = skid_q;
    if (ir_valid_q && ir_ready) ir_valid_d = 1'b0;
    if (flush) begin
      ir_valid_d = 1'b0;
      skid_d     = '0;
      pc_d       = next_pc;
    end else begin
      if (state_q == S_REQ && imem_ack && !slot_free) skid_d = imem_rdata;
      if (ir_load) begin
        ir_d       = load_word;
        ir_pc_d    = pc_q;
        ir_pc_1_d  = pc_inc;
        ir_valid_d = 1'b1;
        pc_d       = next_pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_pc_1_q  <= '0;
      ir_valid_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_pc_1_q  <= ir_pc_1_d;
      ir_valid_q <= ir_valid_d;
      skid_q     <= skid_d;
    end
  end

  assign pc        = pc_q;
  assign pc_1      = pc_inc;
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_pc_1   = ir_pc_1_q;
  assign ir_valid  = ir_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (ir_load) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (ir_valid_q && !ir_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule
